keypad_top: RTL and testbench

//  4x4 matrix-keypad scanner with debounce and binary key encoding. Drives one

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_debounce.sv | 56 +++++
 rtl/keypad_top.sv | 107 ++++++++++
 tb/tb_keypad_top.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 matrix-keypad scanner.
package keypad_pkg;

    localparam int ROW_COUNT = 4;
    localparam int COL_COUNT = 4;
    localparam int KEY_W     = 4;

    // One-cold row drive patterns, row 0 first
    localparam logic [ROW_COUNT-1:0] ROW0_SEL = 4'b1110;
    localparam logic [ROW_COUNT-1:0] ROW1_SEL = 4'b1101;
    localparam logic [ROW_COUNT-1:0] ROW2_SEL = 4'b1011;
    localparam logic [ROW_COUNT-1:0] ROW3_SEL = 4'b0111;

    // One scan frame outcome: valid=0 means no contact anywhere in the frame
    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] code;
    } key_result_t;

    // "None" always carries a zero code so whole-struct comparisons are exact
    localparam key_result_t NO_KEY = '{valid: 1'b0, code: '0};

    // Maps a row index to its one-cold drive pattern
    function automatic logic [ROW_COUNT-1:0] row_sel_for(input logic [1:0] idx);
        logic [ROW_COUNT-1:0] sel;
        case (idx)
            2'd0:    sel = ROW0_SEL;
            2'd1:    sel = ROW1_SEL;
            2'd2:    sel = ROW2_SEL;
            default: sel = ROW3_SEL;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: accepts a new key result only after it has been
// reported for DEBOUNCE_FRAMES consecutive scan frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_valid,
    input  key_result_t      frame_result,
    output logic [KEY_W-1:0] enc_out,
    output logic             pressed
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] next_cnt;
    key_result_t   prev_result;

    // A repeat of the previous result extends the run (saturating); anything new restarts it at one
    always_comb begin
        next_cnt = stable_cnt;
        if (frame_result == prev_result) begin
            if (stable_cnt < CW'(DEBOUNCE_FRAMES)) begin
                next_cnt = stable_cnt + 1'b1;
            end
        end else begin
            next_cnt = CW'(1);
        end
    end

    // Update the run at each frame boundary and commit outputs once the run is long enough;
    // the code is kept on release so the user logic can still read the last key
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt  <= '0;
            prev_result <= NO_KEY;
            enc_out     <= '0;
            pressed     <= 1'b0;
        end else if (frame_valid) begin
            stable_cnt  <= next_cnt;
            prev_result <= frame_result;
            if (next_cnt == CW'(DEBOUNCE_FRAMES)) begin
                if (frame_result.valid) begin
                    enc_out <= frame_result.code;
                    pressed <= 1'b1;
                end else begin
                    pressed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_top.sv
// 4x4 matrix-keypad scanner: rotates an active-low row drive, samples the
// active-low columns at the end of each row dwell, reduces each frame to a
// single prioritised key result and hands it to the debouncer.
module keypad_top
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1024,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COL_COUNT-1:0] in,
    output logic [ROW_COUNT-1:0] row_select,
    output logic [KEY_W-1:0]     enc_out,
    output logic                 pressed
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] dwell_cnt;
    logic [1:0]    row_idx;
    logic          last_dwell;
    logic          row_hit;
    logic [1:0]    hit_col;
    key_result_t   frame_acc;
    key_result_t   frame_now;
    logic          frame_strobe;
    key_result_t   frame_result;

    // The last dwell cycle of a row is both the sampling point and the row-advance point
    assign last_dwell = (dwell_cnt == DW'(SCAN_DIV - 1));

    // Dwell counter and row index: hold each row SCAN_DIV cycles, wrap 3 -> 0 with no idle slot
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            row_idx   <= 2'd0;
        end else if (last_dwell) begin
            dwell_cnt <= '0;
            row_idx   <= row_idx + 2'd1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Registered row drive so the keypad pins never see decode glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            row_select <= ROW0_SEL;
        end else if (last_dwell) begin
            row_select <= row_sel_for(row_idx + 2'd1);
        end
    end

    // Lowest pulled-low column in the currently driven row
    always_comb begin
        row_hit = (in != '1);
        hit_col = 2'd0;
        if (!in[0]) begin
            hit_col = 2'd0;
        end else if (!in[1]) begin
            hit_col = 2'd1;
        end else if (!in[2]) begin
            hit_col = 2'd2;
        end else if (!in[3]) begin
            hit_col = 2'd3;
        end
    end

    // Frame result so far: row 0 starts a fresh frame, earlier rows keep priority over later ones
    always_comb begin
        frame_now = (row_idx == 2'd0) ? NO_KEY : frame_acc;
        if (!frame_now.valid && row_hit) begin
            frame_now.valid = 1'b1;
            frame_now.code  = {row_idx, hit_col};
        end
    end

    // Accumulate per-row samples and publish the finished frame one cycle after the row-3 sample
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_acc    <= NO_KEY;
            frame_strobe <= 1'b0;
            frame_result <= NO_KEY;
        end else begin
            frame_strobe <= last_dwell && (row_idx == 2'd3);
            if (last_dwell) begin
                frame_acc <= frame_now;
                if (row_idx == 2'd3) begin
                    frame_result <= frame_now;
                end
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_strobe),
        .frame_result(frame_result),
        .enc_out     (enc_out),
        .pressed     (pressed)
    );

endmodule

// File: tb/tb_keypad_top.sv
// Testbench for keypad_top: a key-matrix keypad model drives the columns,
// a frame/history reference model predicts every output cycle by cycle.
module tb_keypad_top;

    localparam int S     = 4;
    localparam int D     = 4;
    localparam int FRAME = 4 * S;
    localparam int HOLD  = 6 * FRAME;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  in;
    logic [3:0]  row_select;
    logic [3:0]  enc_out;
    logic        pressed;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  enc;
        logic        pressed;
    } vec_t;

    vec_t       vecs[14];
    logic [3:0] row_tab[4];

    // Reference model state
    int         n = 0;
    logic [3:0] samp[4];
    bit         pend = 0;
    int         pend_res = -1;
    int         hist[$];
    int         mrow;
    bit         same;
    logic [3:0] exp_enc = '0;
    bit         exp_pressed = 0;
    logic [3:0] exp_row;
    bit         check_en = 0;
    bit         watch_rise = 0;
    bit         rise_seen = 0;
    bit         watch_drop = 0;
    bit         drop_seen = 0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its row line to its column line
    always_comb begin
        in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_select[r]) in = in & ~keys[r*4 +: 4];
        end
    end

    keypad_top #(
        .SCAN_DIV       (S),
        .DEBOUNCE_FRAMES(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .row_select(row_select),
        .enc_out   (enc_out),
        .pressed   (pressed)
    );

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] k, input int cycles);
        keys = k;
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: frame = sampled contacts of rows 0..3, result = lowest key index,
    // outputs follow the last D frame results once they all agree
    always @(posedge clk) begin
        if (rst) begin
            n = 0;
            pend = 0;
            hist.delete();
            exp_enc = '0;
            exp_pressed = 0;
        end else begin
            if (pend) begin
                hist.push_back(pend_res);
                if (hist.size() > D) void'(hist.pop_front());
                same = 1;
                foreach (hist[j]) if (hist[j] != hist[0]) same = 0;
                if (hist.size() == D && same) begin
                    if (hist[0] >= 0) begin
                        exp_enc = 4'(hist[0]);
                        exp_pressed = 1;
                    end else begin
                        exp_pressed = 0;
                    end
                end
                pend = 0;
            end
            if (n % S == S - 1) begin
                mrow = (n / S) % 4;
                samp[mrow] = keys[mrow*4 +: 4];
                if (mrow == 3) begin
                    pend_res = -1;
                    for (int idx = 0; idx < 16; idx++)
                        if (pend_res < 0 && samp[idx/4][idx%4]) pend_res = idx;
                    pend = 1;
                end
            end
            n++;
        end
    end

    // Cycle-by-cycle comparison against the model, plus glitch/drop monitors
    always @(negedge clk) begin
        if (check_en) begin
            exp_row = 4'hF & ~(4'b0001 << ((n / S) % 4));
            check_output("row_select", 16'(row_select), 16'(exp_row));
            check_output("enc_out", 16'(enc_out), 16'(exp_enc));
            check_output("pressed", 16'(pressed), 16'(exp_pressed));
            if (watch_rise && pressed) rise_seen = 1;
            if (watch_drop && !pressed) drop_seen = 1;
        end
    end

    initial begin
        row_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        vecs[0]  = '{16'h1111, 4'd0,  1'b1};
        vecs[1]  = '{16'h0000, 4'd0,  1'b0};
        vecs[2]  = '{16'h2222, 4'd1,  1'b1};
        vecs[3]  = '{16'h0000, 4'd1,  1'b0};
        vecs[4]  = '{16'h4444, 4'd2,  1'b1};
        vecs[5]  = '{16'h0000, 4'd2,  1'b0};
        vecs[6]  = '{16'h8888, 4'd3,  1'b1};
        vecs[7]  = '{16'h0000, 4'd3,  1'b0};
        vecs[8]  = '{16'h0400, 4'd10, 1'b1};
        vecs[9]  = '{16'h0000, 4'd10, 1'b0};
        vecs[10] = '{16'h0090, 4'd4,  1'b1};
        vecs[11] = '{16'h8000, 4'd15, 1'b1};
        vecs[12] = '{16'h8001, 4'd0,  1'b1};
        vecs[13] = '{16'h0000, 4'd0,  1'b0};

        // Reset held for five cycles
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_output("reset row_select", 16'(row_select), 16'h000E);
        check_output("reset enc_out", 16'(enc_out), 16'h0000);
        check_output("reset pressed", 16'(pressed), 16'h0000);
        check_en = 1;
        rst = 1'b0;

        // Row rotation order over two frames
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i > 0) @(negedge clk);
            check_output("rotation", 16'(row_select), 16'(row_tab[(i / S) % 4]));
        end
        @(negedge clk);

        // Table of held key patterns with their settled outputs
        for (int v = 0; v < 14; v++) begin
            apply_stimulus(vecs[v].keys, HOLD);
            check_output($sformatf("vec%0d enc_out", v), 16'(enc_out), 16'(vecs[v].enc));
            check_output($sformatf("vec%0d pressed", v), 16'(pressed), 16'(vecs[v].pressed));
        end

        // Contact shorter than a frame never produces a press
        rise_seen = 0;
        watch_rise = 1;
        apply_stimulus(16'h0001, 2 * S);
        apply_stimulus(16'h0000, HOLD);
        watch_rise = 0;
        check_output("glitch pressed rise", 16'(rise_seen), 16'h0000);

        // Direct change from key 5 to key 6 without releasing
        apply_stimulus(16'h0020, HOLD);
        check_output("key5 enc_out", 16'(enc_out), 16'd5);
        check_output("key5 pressed", 16'(pressed), 16'd1);
        drop_seen = 0;
        watch_drop = 1;
        apply_stimulus(16'h0040, HOLD);
        watch_drop = 0;
        check_output("key6 enc_out", 16'(enc_out), 16'd6);
        check_output("key6 pressed", 16'(pressed), 16'd1);
        check_output("key5->6 pressed drop", 16'(drop_seen), 16'h0000);

        // Reset while a key is held
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("midreset row_select", 16'(row_select), 16'h000E);
        check_output("midreset enc_out", 16'(enc_out), 16'h0000);
        check_output("midreset pressed", 16'(pressed), 16'h0000);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        apply_stimulus(16'h0040, HOLD);
        check_output("post-reset key6 enc_out", 16'(enc_out), 16'd6);

        // Randomized key activity checked continuously against the model
        for (int it = 0; it < 40; it++) begin
            int sel;
            logic [15:0] k;
            sel = $urandom_range(0, 2);
            if (sel == 0) k = 16'h0000;
            else if (sel == 1) k = 16'(16'h0001 << $urandom_range(0, 15));
            else k = 16'($urandom);
            apply_stimulus(k, $urandom_range(1, 120));
        end
        apply_stimulus(16'h0000, HOLD);
        check_output("final pressed", 16'(pressed), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
